// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: slot ordering inside a fetched bundle, the
// instruction field positions of the register sources, and a packed bundle
// record for code working at the default instruction and PC widths.
package vliw_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_IXU1 = 0;
  localparam int unsigned SLOT_IXU2 = 1;
  localparam int unsigned SLOT_LSU  = 2;
  localparam int unsigned SLOT_BRU  = 3;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC_W      = 32;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned RS1_LSB   = 15;
  localparam int unsigned RS2_LSB   = 20;

  // Field order mirrors the flat bundle bus: ixu1 in the low bits, bru on top.
  typedef struct packed {
    logic [INSTR_W-1:0] bru;
    logic [INSTR_W-1:0] lsu;
    logic [INSTR_W-1:0] ixu2;
    logic [INSTR_W-1:0] ixu1;
    logic [PC_W-1:0]    pc;
  } bundle_t;

endpackage

// File: rtl/bundle_slot_fields.sv
// Per-slot decode helper for the head bundle.
// Ports:
//   instr       - raw slot instruction read from the queue head
//   valid       - head entry valid
//   gated_instr - instr when valid, else 0
//   rs1, rs2    - register source indices (instr[19:15], instr[24:20]), 0 when invalid
// Forcing the sources to x0 when invalid keeps the hazard unit from matching
// against stale storage contents.
module bundle_slot_fields
  import vliw_pkg::*;
#(
  parameter int unsigned INSTR_W = 32
) (
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 valid,
  output logic [INSTR_W-1:0]   gated_instr,
  output logic [REG_IDX_W-1:0] rs1,
  output logic [REG_IDX_W-1:0] rs2
);

  always_comb begin
    gated_instr = '0;
    rs1         = '0;
    rs2         = '0;
    if (valid) begin
      gated_instr = instr;
      rs1         = instr[RS1_LSB +: REG_IDX_W];
      rs2         = instr[RS2_LSB +: REG_IDX_W];
    end
  end

endmodule

// File: rtl/bundle_fetch_queue.sv
// Circular buffer of fetched 4-slot VLIW bundles between fetch and decode.
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   fq_in_valid/_ready   - fetch handshake; ready = queue not full
//   fq_in_pc, fq_in_bundle - incoming PC and bundle (ixu1 lowest, bru highest)
//   stall_in             - hazard stall, holds the head entry
//   flush_in             - branch redirect, empties the queue
//   dc_valid, dc_pc, dc_*_instr - head entry to decode (0 when empty)
//   dc_*_rs1, dc_*_rs2   - head register sources to hazard detection
//   fq_count             - current occupancy
// No fall-through path: a pushed bundle is visible on the head one cycle later.
module bundle_fetch_queue
  import vliw_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fq_in_valid,
  output logic                         fq_in_ready,
  input  logic [PC_W-1:0]              fq_in_pc,
  input  logic [4*INSTR_W-1:0]         fq_in_bundle,
  input  logic                         stall_in,
  input  logic                         flush_in,
  output logic                         dc_valid,
  output logic [PC_W-1:0]              dc_pc,
  output logic [INSTR_W-1:0]           dc_ixu1_instr,
  output logic [INSTR_W-1:0]           dc_ixu2_instr,
  output logic [INSTR_W-1:0]           dc_lsu_instr,
  output logic [INSTR_W-1:0]           dc_bru_instr,
  output logic [REG_IDX_W-1:0]         dc_ixu1_rs1,
  output logic [REG_IDX_W-1:0]         dc_ixu1_rs2,
  output logic [REG_IDX_W-1:0]         dc_ixu2_rs1,
  output logic [REG_IDX_W-1:0]         dc_ixu2_rs2,
  output logic [REG_IDX_W-1:0]         dc_lsu_rs1,
  output logic [REG_IDX_W-1:0]         dc_lsu_rs2,
  output logic [REG_IDX_W-1:0]         dc_bru_rs1,
  output logic [REG_IDX_W-1:0]         dc_bru_rs2,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;

  logic [PC_W-1:0]      pc_mem     [DEPTH];
  logic [4*INSTR_W-1:0] bundle_mem [DEPTH];
  logic [4*INSTR_W-1:0] head_bundle;

  logic [INSTR_W-1:0]   slot_instr [NUM_SLOTS];
  logic [REG_IDX_W-1:0] slot_rs1   [NUM_SLOTS];
  logic [REG_IDX_W-1:0] slot_rs2   [NUM_SLOTS];

  assign fq_in_ready = (count != FULL);
  assign dc_valid    = (count != '0);
  assign fq_count    = count;

  // Flush suppresses both the push and the pop of its own cycle.
  assign push = fq_in_valid && fq_in_ready && !flush_in;
  assign pop  = dc_valid && !stall_in && !flush_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]     <= fq_in_pc;
      bundle_mem[wr_ptr] <= fq_in_bundle;
    end
  end

  assign head_bundle = bundle_mem[rd_ptr];
  assign dc_pc       = dc_valid ? pc_mem[rd_ptr] : '0;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    bundle_slot_fields #(
      .INSTR_W (INSTR_W)
    ) u_fields (
      .instr       (head_bundle[s*INSTR_W +: INSTR_W]),
      .valid       (dc_valid),
      .gated_instr (slot_instr[s]),
      .rs1         (slot_rs1[s]),
      .rs2         (slot_rs2[s])
    );
  end

  assign dc_ixu1_instr = slot_instr[SLOT_IXU1];
  assign dc_ixu2_instr = slot_instr[SLOT_IXU2];
  assign dc_lsu_instr  = slot_instr[SLOT_LSU];
  assign dc_bru_instr  = slot_instr[SLOT_BRU];

  assign dc_ixu1_rs1 = slot_rs1[SLOT_IXU1];
  assign dc_ixu1_rs2 = slot_rs2[SLOT_IXU1];
  assign dc_ixu2_rs1 = slot_rs1[SLOT_IXU2];
  assign dc_ixu2_rs2 = slot_rs2[SLOT_IXU2];
  assign dc_lsu_rs1  = slot_rs1[SLOT_LSU];
  assign dc_lsu_rs2  = slot_rs2[SLOT_LSU];
  assign dc_bru_rs1  = slot_rs1[SLOT_BRU];
  assign dc_bru_rs2  = slot_rs2[SLOT_BRU];

endmodule

// File: tb/tb_bundle_fetch_queue.sv
module tb_bundle_fetch_queue;
  import vliw_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fq_in_valid = 1'b0;
  logic        fq_in_ready;
  logic [31:0] fq_in_pc = '0;
  logic [127:0] fq_in_bundle = '0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        dc_valid;
  logic [31:0] dc_pc;
  logic [31:0] dc_ixu1_instr, dc_ixu2_instr, dc_lsu_instr, dc_bru_instr;
  logic [4:0]  dc_ixu1_rs1, dc_ixu1_rs2, dc_ixu2_rs1, dc_ixu2_rs2;
  logic [4:0]  dc_lsu_rs1, dc_lsu_rs2, dc_bru_rs1, dc_bru_rs2;
  logic [2:0]  fq_count;

  bundle_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fq_in_valid(fq_in_valid), .fq_in_ready(fq_in_ready),
    .fq_in_pc(fq_in_pc), .fq_in_bundle(fq_in_bundle),
    .stall_in(stall_in), .flush_in(flush_in),
    .dc_valid(dc_valid), .dc_pc(dc_pc),
    .dc_ixu1_instr(dc_ixu1_instr), .dc_ixu2_instr(dc_ixu2_instr),
    .dc_lsu_instr(dc_lsu_instr), .dc_bru_instr(dc_bru_instr),
    .dc_ixu1_rs1(dc_ixu1_rs1), .dc_ixu1_rs2(dc_ixu1_rs2),
    .dc_ixu2_rs1(dc_ixu2_rs1), .dc_ixu2_rs2(dc_ixu2_rs2),
    .dc_lsu_rs1(dc_lsu_rs1), .dc_lsu_rs2(dc_lsu_rs2),
    .dc_bru_rs1(dc_bru_rs1), .dc_bru_rs2(dc_bru_rs2),
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  bundle_t sb[$];
  int      mcount = 0;
  int      n_checks = 0;
  int      n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference occupancy model; records every accepted bundle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      mcount = 0;
    end else if (flush_in) begin
      sb.delete();
      mcount = 0;
    end else begin
      bit pu, po;
      pu = fq_in_valid && (mcount != DEPTH);
      po = (mcount != 0) && !stall_in;
      if (pu) sb.push_back(bundle_t'({fq_in_bundle, fq_in_pc}));
      mcount = mcount + (pu ? 1 : 0) - (po ? 1 : 0);
    end
  end

  // Monitor: compare head against the oldest expected bundle; retire on pop.
  always @(negedge clk) begin
    check("count", 64'(fq_count), 64'(mcount));
    check("ready", 64'(fq_in_ready), 64'(mcount != DEPTH));
    check("dc_valid", 64'(dc_valid), 64'(mcount != 0));
    if (mcount == 0) begin
      check("empty_gate", {dc_pc, dc_ixu1_instr | dc_ixu2_instr | dc_lsu_instr | dc_bru_instr},
            64'd0);
      check("empty_rs", 64'({dc_ixu1_rs1, dc_ixu1_rs2, dc_ixu2_rs1, dc_ixu2_rs2,
                             dc_lsu_rs1, dc_lsu_rs2, dc_bru_rs1, dc_bru_rs2}), 64'd0);
    end else if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'(mcount));
    end else begin
      bundle_t e;
      e = sb[0];
      check("dc_pc", 64'(dc_pc), 64'(e.pc));
      check("ixu1", 64'(dc_ixu1_instr), 64'(e.ixu1));
      check("ixu2", 64'(dc_ixu2_instr), 64'(e.ixu2));
      check("lsu", 64'(dc_lsu_instr), 64'(e.lsu));
      check("bru", 64'(dc_bru_instr), 64'(e.bru));
      check("ixu1_rs", 64'({dc_ixu1_rs1, dc_ixu1_rs2}), 64'({e.ixu1[19:15], e.ixu1[24:20]}));
      check("ixu2_rs", 64'({dc_ixu2_rs1, dc_ixu2_rs2}), 64'({e.ixu2[19:15], e.ixu2[24:20]}));
      check("lsu_rs", 64'({dc_lsu_rs1, dc_lsu_rs2}), 64'({e.lsu[19:15], e.lsu[24:20]}));
      check("bru_rs", 64'({dc_bru_rs1, dc_bru_rs2}), 64'({e.bru[19:15], e.bru[24:20]}));
      if (!stall_in && !flush_in) void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc,
                        input logic [31:0] b3, input logic [31:0] b2,
                        input logic [31:0] b1, input logic [31:0] b0);
    fq_in_valid  = v;
    fq_in_pc     = pc;
    fq_in_bundle = {b3, b2, b1, b0};
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // add x10,x10,x11 in ixu1; lw x3,8(x2) in lsu
    set_in(1'b1, 32'h100, 32'h0, 32'h0081_2183, 32'h0, 32'h00B5_0533);
    step();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("t1_valid", 64'(dc_valid), 64'd1);
    check("t1_pc", 64'(dc_pc), 64'h100);
    check("t1_rs1", 64'(dc_ixu1_rs1), 64'd10);
    check("t1_rs2", 64'(dc_ixu1_rs2), 64'd11);
    check("t1_lsu_rs1", 64'(dc_lsu_rs1), 64'd2);
    check("t1_count", 64'(fq_count), 64'd1);
    step();

    // Fill under stall, then attempt a fifth push.
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(i * 16), 32'h00C5_8063 + 32'(i), 32'h0062_A023,
             32'h0031_0133 + 32'(i << 15), 32'h0020_80B3);
      step();
    end
    check("full_count", 64'(fq_count), 64'd4);
    check("full_ready", 64'(fq_in_ready), 64'd0);
    set_in(1'b1, 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    check("full_hold_pc", 64'(dc_pc), 64'h0);
    check("full_hold_count", 64'(fq_count), 64'd4);

    // Release stall and stream for 10 cycles across pointer wrap.
    stall_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 32'h50 + 32'(k * 16), 32'(k) << 20, 32'(k) << 15,
             32'h0108_0000 + 32'(k), 32'h00F7_8000 | (32'(k) << 7));
      step();
    end
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (6) step();
    check("drain_count", 64'(fq_count), 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);

    // Three entries, then flush alongside a push.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h200 + 32'(i * 16), 32'h01F0_8000, 32'h00F7_8000, 32'h0050_0000, 32'h0001_8000);
      step();
    end
    flush_in = 1'b1;
    set_in(1'b1, 32'hDEAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    flush_in = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("flush_count", 64'(fq_count), 64'd0);
    check("flush_valid", 64'(dc_valid), 64'd0);
    check("flush_rs", 64'({dc_ixu1_rs1, dc_ixu2_rs1, dc_lsu_rs1, dc_bru_rs2}), 64'd0);
    stall_in = 1'b0;

    // Idle with an empty queue.
    repeat (5) step();
    check("idle_count", 64'(fq_count), 64'd0);
    check("idle_valid", 64'(dc_valid), 64'd0);

    // Two entries, then asynchronous reset mid-cycle.
    stall_in = 1'b1;
    set_in(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0041_8000);
    step();
    set_in(1'b1, 32'h310, 32'h0, 32'h0, 32'h0, 32'h0042_0000);
    step();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("pre_rst_count", 64'(fq_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(dc_valid), 64'd0);
    check("rst_ready", 64'(fq_in_ready), 64'd1);
    check("rst_pc", 64'(dc_pc), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_in(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 32'h00B5_0533);
    step();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("post_rst_pc", 64'(dc_pc), 64'h400);
    check("post_rst_count", 64'(fq_count), 64'd1);
    check("post_rst_rs1", 64'(dc_ixu1_rs1), 64'd10);
    stall_in = 1'b0;
    repeat (3) step();
    check("final_count", 64'(fq_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
